shift_rotate_engine: RTL and testbench

Parametrised multi-cycle shift/rotate register with parallel load, the successor to the fixed 8-bit rotating register. It accepts one command per start pulse, performs `amount` single-bit steps at one step per clock, and reports completion with a busy/done handshake. It is intended as the B-operand register next to the ALU datapath, with `q` also driving LEDs and hex displays.

---
 rtl/shift_rotate_engine.sv | 139 +++++++++++++
 tb/tb_shift_rotate_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_engine.sv
// Multi-cycle shift/rotate register with parallel load and a busy/done handshake.
// Optional `SERIAL_IN_EN adds a serial_in port used as the fill bit for logical shifts.
module shift_rotate_engine #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
`ifdef SERIAL_IN_EN
  input  logic             serial_in,
`endif
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_ROR   = 3'b001;
  localparam logic [2:0] OP_ROL   = 3'b010;
  localparam logic [2:0] OP_SRL   = 3'b011;
  localparam logic [2:0] OP_SLL   = 3'b100;
  localparam logic [2:0] OP_SRA   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               carry_q, carry_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               fill;

`ifdef SERIAL_IN_EN
  assign fill = serial_in;
`else
  assign fill = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_LOAD;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // DONE accepts a new command exactly like IDLE, which gives back-to-back issue.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = DONE;
          case (op)
            OP_LOAD: begin
              q_d     = data_in;
              carry_d = 1'b0;
            end
            OP_CLEAR: begin
              q_d     = '0;
              carry_d = 1'b0;
            end
            OP_NOP: begin
            end
            default: begin
              if (amount != '0) begin
                op_d    = op;
                cnt_d   = amount;
                state_d = RUN;
              end
            end
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
        end
        // One single-bit step per edge; carry takes the bit leaving the register.
        case (op_q)
          OP_ROR: begin
            q_d     = {q_q[0], q_q[WIDTH-1:1]};
            carry_d = q_q[0];
          end
          OP_ROL: begin
            q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            carry_d = q_q[WIDTH-1];
          end
          OP_SRL: begin
            q_d     = {fill, q_q[WIDTH-1:1]};
            carry_d = q_q[0];
          end
          OP_SLL: begin
            q_d     = {q_q[WIDTH-2:0], fill};
            carry_d = q_q[WIDTH-1];
          end
          OP_SRA: begin
            q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            carry_d = q_q[0];
          end
          default: begin
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign q         = q_q;
  assign carry_out = carry_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_shift_rotate_engine.sv
// Self-checking bench for shift_rotate_engine: fixed vectors, hand-written
// handshake/reset sequences, and randomized commands against a reference model.
module tb_shift_rotate_engine;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clock;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] amount;
  logic [W-1:0]  dataIn;
  logic [W-1:0]  q;
  logic          carryOut;
  logic          busy;
  logic          done;
`ifdef SERIAL_IN_EN
  logic          serialIn;
`endif

  shift_rotate_engine #(.WIDTH(W), .AMT_W(AW)) dut (
    .clock    (clock),
    .reset    (reset),
`ifdef SERIAL_IN_EN
    .serial_in(serialIn),
`endif
    .start    (start),
    .op       (op),
    .amount   (amount),
    .data_in  (dataIn),
    .q        (q),
    .carry_out(carryOut),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] mq;
  logic         mc;
  logic         modelFill;

  typedef struct {
    logic [W-1:0]  init;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  data;
    logic [W-1:0]  expQ;
    logic          expC;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Whole-command reference: the result of n steps computed directly, not step by step.
  task automatic modelCmd(input logic [2:0] o, input logic [AW-1:0] a, input logic [W-1:0] d);
    int n;
    int k;
    logic [W-1:0] ones;
    n    = int'(a);
    ones = '1;
    case (o)
      3'd0: begin mq = d; mc = 1'b0; end
      3'd6: begin mq = '0; mc = 1'b0; end
      3'd7: begin end
      default: begin
        if (n != 0) begin
          case (o)
            3'd1: begin
              k  = n % W;
              mc = mq[(n-1) % W];
              mq = (mq >> k) | (mq << (W - k));
            end
            3'd2: begin
              k  = n % W;
              mc = mq[W - 1 - ((n-1) % W)];
              mq = (mq << k) | (mq >> (W - k));
            end
            3'd3: begin
              mc = (n <= W) ? mq[n-1] : modelFill;
              if (n >= W) mq = modelFill ? ones : '0;
              else        mq = (mq >> n) | (modelFill ? (ones << (W - n)) : '0);
            end
            3'd4: begin
              mc = (n <= W) ? mq[W-n] : modelFill;
              if (n >= W) mq = modelFill ? ones : '0;
              else        mq = (mq << n) | (modelFill ? (ones >> (W - n)) : '0);
            end
            default: begin
              mc = (n <= W) ? mq[n-1] : mq[W-1];
              mq = W'($signed(mq) >>> n);
            end
          endcase
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [AW-1:0] a, input logic [W-1:0] d);
    logic multi;
    int   cycles;
    multi = (o >= 3'd1) && (o <= 3'd5) && (a != '0);
    modelCmd(o, a, d);
    op     = o;
    amount = a;
    dataIn = d;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    op     = 3'($urandom);
    amount = AW'($urandom);
    dataIn = W'($urandom);
    checkOutput("busyAfterAccept", 32'(busy), 32'(multi));
    cycles = 0;
    while (!done && cycles < 40) begin
      tick();
      cycles++;
    end
    if (!done) begin
      checkOutput("doneTimeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", cycles, multi ? int'(a) : 0);
      checkOutput("busyAtDone", 32'(busy), 32'd0);
      checkOutput("q", 32'(q), 32'(mq));
      checkOutput("carry", 32'(carryOut), 32'(mc));
    end
    tick();
    checkOutput("donePulseWidth", 32'(done), 32'd0);
    checkOutput("idleBusy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic sawDone;
    logic [2:0] rop;
    logic [AW-1:0] ramt;
    logic [W-1:0] rdata;

    vecs[0]  = '{8'h81, 3'd1, 4'd3,  8'hFF, 8'h30, 1'b0};
    vecs[1]  = '{8'h81, 3'd2, 4'd9,  8'hFF, 8'h03, 1'b1};
    vecs[2]  = '{8'h90, 3'd5, 4'd2,  8'hFF, 8'hE4, 1'b0};
    vecs[3]  = '{8'h90, 3'd3, 4'd2,  8'hFF, 8'h24, 1'b0};
    vecs[4]  = '{8'h90, 3'd4, 4'd15, 8'hFF, 8'h00, 1'b0};
    vecs[5]  = '{8'hA5, 3'd7, 4'd7,  8'hFF, 8'hA5, 1'b0};
    vecs[6]  = '{8'h5A, 3'd6, 4'd3,  8'hFF, 8'h00, 1'b0};
    vecs[7]  = '{8'h3C, 3'd1, 4'd0,  8'hFF, 8'h3C, 1'b0};
    vecs[8]  = '{8'h01, 3'd3, 4'd1,  8'hFF, 8'h00, 1'b1};
    vecs[9]  = '{8'h80, 3'd4, 4'd1,  8'hFF, 8'h00, 1'b1};
    vecs[10] = '{8'h80, 3'd5, 4'd10, 8'hFF, 8'hFF, 1'b1};
    vecs[11] = '{8'h01, 3'd1, 4'd8,  8'hFF, 8'h01, 1'b0};
    vecs[12] = '{8'h00, 3'd0, 4'd5,  8'hC3, 8'hC3, 1'b0};

    reset     = 1'b1;
    start     = 1'b0;
    op        = 3'd0;
    amount    = '0;
    dataIn    = '0;
    modelFill = 1'b0;
    mq        = '0;
    mc        = 1'b0;
`ifdef SERIAL_IN_EN
    serialIn  = 1'b0;
`endif

    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("resetQ", 32'(q), 32'd0);
    checkOutput("resetCarry", 32'(carryOut), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    applyStimulus(3'd0, 4'd0, 8'hA5);
    checkOutput("loadA5", 32'(q), 32'hA5);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(3'd0, 4'd0, vecs[i].init);
      applyStimulus(vecs[i].op, vecs[i].amt, vecs[i].data);
      checkOutput($sformatf("vec%0dQ", i), 32'(q), 32'(vecs[i].expQ));
      checkOutput($sformatf("vec%0dCarry", i), 32'(carryOut), 32'(vecs[i].expC));
    end

    // Nop and zero-amount shifts must preserve a carry of 1.
    applyStimulus(3'd0, 4'd0, 8'h01);
    applyStimulus(3'd3, 4'd1, 8'h00);
    applyStimulus(3'd7, 4'd0, 8'h55);
    checkOutput("nopKeepsCarry", 32'(carryOut), 32'd1);
    applyStimulus(3'd1, 4'd0, 8'h55);
    checkOutput("zeroAmtKeepsCarry", 32'(carryOut), 32'd1);

    // Start during RUN is ignored; start on the done cycle is accepted.
    applyStimulus(3'd0, 4'd0, 8'h81);
    op = 3'd1; amount = 4'd3; start = 1'b1;
    tick();
    checkOutput("trajBusy", 32'(busy), 32'd1);
    checkOutput("trajQ0", 32'(q), 32'h81);
    op = 3'd6; amount = 4'd2;
    tick();
    checkOutput("trajQ1", 32'(q), 32'hC0);
    tick();
    checkOutput("trajQ2", 32'(q), 32'h60);
    start = 1'b0;
    tick();
    checkOutput("trajQ3", 32'(q), 32'h30);
    checkOutput("trajDone", 32'(done), 32'd1);
    checkOutput("trajCarry", 32'(carryOut), 32'd0);
    start = 1'b1; op = 3'd6;
    tick();
    start = 1'b0;
    checkOutput("b2bClearQ", 32'(q), 32'h00);
    checkOutput("b2bDone", 32'(done), 32'd1);
    tick();
    checkOutput("b2bDoneDrop", 32'(done), 32'd0);
    mq = '0;
    mc = 1'b0;

    // Asynchronous reset in the middle of a rotate.
    applyStimulus(3'd0, 4'd0, 8'h81);
    op = 3'd1; amount = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("midRunQ", 32'(q), 32'h60);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncResetQ", 32'(q), 32'd0);
    checkOutput("asyncResetBusy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    checkOutput("noDoneAfterReset", 32'(sawDone), 32'd0);
    mq = '0;
    mc = 1'b0;

    // Serial fill into a logical left shift.
    applyStimulus(3'd0, 4'd0, 8'h00);
`ifdef SERIAL_IN_EN
    serialIn  = 1'b1;
    modelFill = 1'b1;
    applyStimulus(3'd4, 4'd4, 8'hFF);
    checkOutput("serialFillQ", 32'(q), 32'h0F);
    serialIn  = 1'b0;
    modelFill = 1'b0;
`else
    applyStimulus(3'd4, 4'd4, 8'hFF);
    checkOutput("serialFillQ", 32'(q), 32'h00);
`endif

    for (int i = 0; i < 40; i++) begin
      rop   = 3'($urandom);
      ramt  = AW'($urandom_range(0, 15));
      rdata = W'($urandom);
      applyStimulus(rop, ramt, rdata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
